// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: 4-bit lookahead groups plus a group G/P lookahead unit.
// Optional macro CLA_INPUT_REG_EN adds a reset-cleared operand register stage (2-cycle latency).
module cla_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] number1,
    input  logic [WIDTH-1:0] number2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned GROUPS = WIDTH / 4;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              op_cin;

`ifdef CLA_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
        end else begin
            op_a   <= number1;
            op_b   <= number2;
            op_cin <= cin;
        end
    end
`else
    always_comb begin
        op_a   = number1;
        op_b   = number2;
        op_cin = cin;
    end
`endif

    logic [WIDTH-1:0]  g;
    logic [WIDTH-1:0]  p;
    logic [WIDTH-1:0]  c;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   grp_c;

    assign g = op_a & op_b;
    assign p = op_a ^ op_b;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : gen_group
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;

        assign gg = g[4*gi +: 4];
        assign pp = p[4*gi +: 4];
        assign ci = grp_c[gi];

        assign c[4*gi]   = ci;
        assign c[4*gi+1] = gg[0] | (pp[0] & ci);
        assign c[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        assign c[4*gi+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                         | (pp[2] & pp[1] & pp[0] & ci);

        assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                         | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p[gi] = &pp;
    end

    // Each group carry is a flat sum of products over lower groups' G/P and cin.
    always_comb begin
        logic acc;
        logic prod;
        grp_c    = '0;
        acc      = 1'b0;
        prod     = 1'b0;
        grp_c[0] = op_cin;
        for (int unsigned k = 1; k <= GROUPS; k++) begin
            acc = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                prod = grp_g[j];
                for (int unsigned m = j + 1; m < k; m++) begin
                    prod = prod & grp_p[m];
                end
                acc = acc | prod;
            end
            prod = op_cin;
            for (int unsigned m = 0; m < k; m++) begin
                prod = prod & grp_p[m];
            end
            grp_c[k] = acc | prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= p ^ c;
            cout <= grp_c[GROUPS];
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed corner cases, a reset-interrupted stream,
// all operand pairs, and random traffic against an arithmetic pipeline model.
module tb_cla_adder;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] number1;
    logic [7:0] number2;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    logic [8:0] pipe [LAT];

    cla_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .number1 (number1),
        .number2 (number2),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {cout,sum}=%h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic rst, input string tag);
        number1 = a;
        number2 = b;
        cin     = ci;
        reset   = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] = '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = 9'(a) + 9'(b) + 9'(ci);
        end
        check(tag, {cout, sum}, pipe[LAT-1]);
    endtask

    // Hold one operand set until it reaches the output, then compare to a fixed constant.
    task automatic hold(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input string tag, input logic [8:0] exp);
        for (int i = 0; i < LAT; i++) step(a, b, ci, 1'b0, tag);
        check({tag, "_const"}, {cout, sum}, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        reset   = 1'b1;
        number1 = '0;
        number2 = '0;
        cin     = 1'b0;

        for (int i = 0; i < 2; i++) begin
            step(8'hAA, 8'h55, 1'b1, 1'b1, "reset");
            check("reset_const", {cout, sum}, 9'h000);
        end

        hold(8'd8,   8'd8,   1'b0, "basic",     9'd16);
        hold(8'd0,   8'd0,   1'b1, "cin_only",  9'd1);
        hold(8'd255, 8'd1,   1'b0, "wrap",      9'h100);
        hold(8'd255, 8'd255, 1'b1, "max",       9'h1FF);
        hold(8'h0F,  8'hF0,  1'b1, "propagate", 9'h100);
        hold(8'h0F,  8'h00,  1'b1, "grp_carry", 9'h010);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            step(ra, rb, rc, (i == 8), "stream");
            if (i == 8) check("stream_reset", {cout, sum}, 9'h000);
        end

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                ra = 8'(a);
                rb = 8'(b);
                step(ra, rb, ra[0] ^ rb[7], 1'b0, "exhaustive");
            end
        end

        for (int i = 0; i < 2000; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
